cic_chan_sched: RTL and testbench
=================================

// Module: cic_chan_sched
// PURPOSE
//  Round-robin scheduler that shares one channel-addressed memory-based CIC decimator engine between NCH input streams.
//  - Each stream is a per-channel strobe + 24-bit sample, e.g. I/Q or multi-receiver.
//  - Holds one pending sample per channel and issues one sample per engine slot.
//  - Drives the engine bank select and tags engine outputs with the source channel.
//  - Sits between the mixers and the CIC engine, which has no reset and no busy output.
// PARAMETERS
//  NCH         2   number of input channels (2..8)
//  CH_W        1   width of channel index; must satisfy 2**CH_W >= NCH
//  ENG_CYCLES  27  engine clocks per input sample (2*STAGES+5 for STAGES=11)
// PORTS
//  clock           in   1         system clock, all logic on rising edge
//  reset           in   1         asynchronous, active-high reset
//  in_strobe       in   NCH       1-cycle sample-valid pulse, one bit per channel
//  in_data         in   NCH*24    signed samples; channel k is bits [24k+23:24k]
//  eng_strobe      out  1         1-cycle sample pulse to engine in_strobe
//  eng_data        out  24        sample to engine, valid while eng_strobe=1
//  eng_ch          out  CH_W      engine bank select; held stable from issue to end of slot
//  eng_out_strobe  in   1         engine output-valid pulse
//  eng_out_data    in   24        engine decimated output
//  out_strobe      out  1         tagged output valid (1 cycle)
//  out_ch          out  CH_W      source channel of out_data
//  out_data        out  24        decimated output sample
//  overrun         out  NCH       sticky overrun flags (only with CIC_SCHED_OVERRUN_EN)
// BEHAVIOUR
//  Reset values: eng_strobe=0, eng_data=0, eng_ch=0, out_strobe=0, out_ch=0, out_data=0, overrun=0, all pending flags=0, rr pointer=NCH-1.
//  Pending capture:
//  - in_strobe[k] latches in_data[k] into hold[k] and sets pend[k].
//  - A strobe on a channel that is already pending overwrites hold[k]; newest sample wins.
//  FSM states:
//  - HOLDOFF (entered on reset): count ENG_CYCLES+1 clocks so any in-flight engine op drains. Input capture is active. Then go to IDLE.
//  - IDLE: if any pend is set, pick the first set channel searching rr+1, rr+2, ... modulo NCH. Then go to ISSUE.
//  - ISSUE (1 cycle): eng_strobe=1, eng_data=hold[sel], eng_ch=sel, rr<=sel, clear pend[sel], load slot counter with ENG_CYCLES. Go to WAIT.
//  - WAIT: decrement the slot counter; on reaching 0, go to IDLE. Issue-to-issue minimum is ENG_CYCLES+2 clocks.
//  - Simultaneous in_strobe[sel] and ISSUE of sel: the issued value is the old hold[sel]. The new sample is kept and pend[sel] stays set.
//  Output path:
//  - eng_out_strobe is registered with 1 cycle latency: out_strobe=1, out_data=eng_out_data, out_ch=eng_ch.
//  - eng_ch does not change until the next ISSUE, so tagging is always correct.
//  - eng_out_strobe during HOLDOFF is discarded (engine state is unknown after reset).
//  Fairness: with all channels continuously pending, issue order is strictly 0,1,..,NCH-1,0,...
//  Reset asserted mid-slot: outputs clear immediately. The engine finishes on its own, covered by HOLDOFF.
// CONFIGURATION
//  CIC_SCHED_OVERRUN_EN defined:
//  - overrun[k] sets when in_strobe[k] arrives while pend[k]=1 and ISSUE of k is not in the same cycle.
//  - overrun[k] is sticky until reset.
//  CIC_SCHED_OVERRUN_EN undefined: the overrun port is tied 0 and has no logic; overwrite behaviour is unchanged.
// STRUCTURE
//  Shared package cic_pkg: FSM state encoding (HOLDOFF, IDLE, ISSUE, WAIT) and constant SAMPLE_W=24.
//  One sub-module cic_rr_pick (combinational round-robin picker: pend, rr -> sel, any). All else inline.
// TESTING
//  1. Reset, then a strobe on ch0 at cycle 5 -> no eng_strobe before HOLDOFF ends (cycle 28), then eng_strobe with eng_ch=0.
//  2. ch0=0x000100 and ch1=0xFFFF00 strobed in the same cycle -> issue ch0, then ch1 exactly ENG_CYCLES+2 clocks later.
//  3. ch1 strobed twice (0x11 then 0x22) before issue -> a single issue with eng_data=0x22; overrun[1]=1 if EN, else overrun=0.
//  4. Engine model returns eng_out_strobe in slot of ch1 with 0x123456 -> next cycle out_strobe=1, out_ch=1, out_data=0x123456.
//  5. All channels strobed every 10 clocks -> issue order 0,1,0,1,...; no channel issued twice in a row.
//  6. Reset pulsed during WAIT -> all outputs 0 immediately; full HOLDOFF is repeated before the next issue.

Source files
------------

// File: rtl/cic_pkg.sv
// Shared definitions for the CIC channel scheduler: FSM encoding and sample width.
package cic_pkg;

  localparam int SAMPLE_W = 24;

  typedef enum logic [1:0] {
    HOLDOFF = 2'd0,
    IDLE    = 2'd1,
    ISSUE   = 2'd2,
    WAIT    = 2'd3
  } state_t;

endpackage

// File: rtl/cic_rr_pick.sv
// Combinational round-robin picker: first pending channel after rr, wrapping mod NCH.
module cic_rr_pick #(
  parameter int NCH  = 2,
  parameter int CH_W = 1
) (
  input  logic [NCH-1:0]  pend,
  input  logic [CH_W-1:0] rr,
  output logic [CH_W-1:0] sel,
  output logic            any
);

  int best;

  // Distance of channel j from rr+1 (0 = highest priority); smallest pending distance wins
  always_comb begin
    sel  = '0;
    any  = 1'b0;
    best = NCH;
    for (int j = 0; j < NCH; j++) begin
      if (pend[j] && (((j + NCH - 1 - int'(rr)) % NCH) < best)) begin
        best = (j + NCH - 1 - int'(rr)) % NCH;
        sel  = CH_W'(j);
        any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cic_chan_sched.sv
// Round-robin scheduler sharing one channel-addressed CIC decimator engine
// between NCH input streams. Optional sticky overrun flags are built when
// CIC_SCHED_OVERRUN_EN is defined; otherwise the overrun port is tied to 0.
module cic_chan_sched
  import cic_pkg::*;
#(
  parameter int NCH        = 2,
  parameter int CH_W       = 1,
  parameter int ENG_CYCLES = 27
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NCH-1:0]          in_strobe,
  input  logic [NCH*SAMPLE_W-1:0] in_data,
  output logic                    eng_strobe,
  output logic [SAMPLE_W-1:0]     eng_data,
  output logic [CH_W-1:0]         eng_ch,
  input  logic                    eng_out_strobe,
  input  logic [SAMPLE_W-1:0]     eng_out_data,
  output logic                    out_strobe,
  output logic [CH_W-1:0]         out_ch,
  output logic [SAMPLE_W-1:0]     out_data,
  output logic [NCH-1:0]          overrun
);

  // Counter serves both the post-reset holdoff (0..ENG_CYCLES) and the slot countdown
  localparam int CNT_W = $clog2(ENG_CYCLES + 2);

  state_t                         state;
  logic [CNT_W-1:0]               cnt;
  logic [CH_W-1:0]                rr;
  logic [CH_W-1:0]                sel_q;
  logic [NCH-1:0]                 pend;
  logic [NCH-1:0][SAMPLE_W-1:0]   hold;
  logic [CH_W-1:0]                pick_sel;
  logic                           pick_any;
  logic                           issue_now;

  assign issue_now = (state == ISSUE);

  cic_rr_pick #(.NCH(NCH), .CH_W(CH_W)) u_pick (
    .pend (pend),
    .rr   (rr),
    .sel  (pick_sel),
    .any  (pick_any)
  );

  // Per-channel capture: newest sample wins; a strobe racing the issue of the
  // same channel keeps pend set so the new sample is issued later
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pend <= '0;
      hold <= '0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (in_strobe[k]) begin
          hold[k] <= in_data[k*SAMPLE_W +: SAMPLE_W];
          pend[k] <= 1'b1;
        end else if (issue_now && (sel_q == CH_W'(k))) begin
          pend[k] <= 1'b0;
        end
      end
    end
  end

  // Scheduler FSM: holdoff drain, pick, issue one sample, wait out the engine slot
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= HOLDOFF;
      cnt        <= '0;
      rr         <= CH_W'(NCH - 1);
      sel_q      <= '0;
      eng_strobe <= 1'b0;
      eng_data   <= '0;
      eng_ch     <= '0;
    end else begin
      eng_strobe <= 1'b0;
      case (state)
        HOLDOFF: begin
          if (cnt == CNT_W'(ENG_CYCLES)) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        IDLE: begin
          if (pick_any) begin
            sel_q <= pick_sel;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          eng_strobe <= 1'b1;
          eng_data   <= hold[sel_q];
          eng_ch     <= sel_q;
          rr         <= sel_q;
          cnt        <= CNT_W'(ENG_CYCLES);
          state      <= WAIT;
        end
        WAIT: begin
          // Leaving at cnt==1 gives ENG_CYCLES+2 clocks issue-to-issue
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) state <= IDLE;
        end
        default: state <= HOLDOFF;
      endcase
    end
  end

  // Tag engine output with the bank it was computed in; drop output while draining
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_strobe <= 1'b0;
      out_ch     <= '0;
      out_data   <= '0;
    end else begin
      out_strobe <= eng_out_strobe && (state != HOLDOFF);
      if (eng_out_strobe && (state != HOLDOFF)) begin
        out_data <= eng_out_data;
        out_ch   <= eng_ch;
      end
    end
  end

`ifdef CIC_SCHED_OVERRUN_EN
  // Sticky flag: a sample overwrote a still-pending one that was not being issued
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overrun <= '0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (in_strobe[k] && pend[k] && !(issue_now && (sel_q == CH_W'(k))))
          overrun[k] <= 1'b1;
      end
    end
  end
`else
  assign overrun = '0;
`endif

endmodule

// File: tb/tb_cic_chan_sched.sv
// Directed bench for cic_chan_sched (NCH=2, ENG_CYCLES=27).
module tb_cic_chan_sched;

  localparam int NCH = 2;
  localparam int CH_W = 1;
  localparam int ENG_CYCLES = 27;
  // First eng_strobe after reset release: holdoff (ENG_CYCLES+1) + IDLE + ISSUE
  localparam int FIRST_ISSUE = ENG_CYCLES + 3;
  localparam int SLOT = ENG_CYCLES + 2;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic [NCH-1:0]  in_strobe = '0;
  logic [NCH*24-1:0] in_data = '0;
  logic            eng_strobe;
  logic [23:0]     eng_data;
  logic [CH_W-1:0] eng_ch;
  logic            eng_out_strobe = 1'b0;
  logic [23:0]     eng_out_data = '0;
  logic            out_strobe;
  logic [CH_W-1:0] out_ch;
  logic [23:0]     out_data;
  logic [NCH-1:0]  overrun;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  cic_chan_sched #(.NCH(NCH), .CH_W(CH_W), .ENG_CYCLES(ENG_CYCLES)) dut (
    .clock          (clock),
    .reset          (reset),
    .in_strobe      (in_strobe),
    .in_data        (in_data),
    .eng_strobe     (eng_strobe),
    .eng_data       (eng_data),
    .eng_ch         (eng_ch),
    .eng_out_strobe (eng_out_strobe),
    .eng_out_data   (eng_out_data),
    .out_strobe     (out_strobe),
    .out_ch         (out_ch),
    .out_data       (out_data),
    .overrun        (overrun)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // Advance one edge; outputs are sampled 1 time unit after it
  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_strobe = '0;
    eng_out_strobe = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b0;
    cyc = 0;
  endtask

  task automatic strobe(input logic [NCH-1:0] m, input logic [23:0] d0, input logic [23:0] d1);
    in_strobe = m;
    in_data = {d1, d0};
    tick();
    in_strobe = '0;
  endtask

  // Wait for the next eng_strobe; returns the edge count it appeared at
  task automatic wait_issue(input string tag, input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (eng_strobe) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) chk({tag, "_timeout"}, 0, 1);
  endtask

  int at, at2, nis;
  logic [NCH-1:0] ov_exp;
  logic [CH_W-1:0] order [$];

  initial begin
    do_reset();
    // Reset state
    chk("rst_eng_strobe", eng_strobe, 0);
    chk("rst_eng_data", eng_data, 0);
    chk("rst_eng_ch", eng_ch, 0);
    chk("rst_out_strobe", out_strobe, 0);
    chk("rst_out_ch", out_ch, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_overrun", overrun, 0);

    // 1: strobe ch0 at edge 5, nothing issued until holdoff completes
    for (int i = 0; i < 4; i++) tick();
    strobe(2'b01, 24'hAAAAAA, 24'h0);
    wait_issue("t1", 60, at);
    chk("t1_issue_cyc", at, FIRST_ISSUE);
    chk("t1_eng_ch", eng_ch, 0);
    chk("t1_eng_data", eng_data, 24'hAAAAAA);
    tick();
    chk("t1_pulse_1cyc", eng_strobe, 0);

    // 2: both channels at once -> ch0 then ch1 one slot later
    do_reset();
    strobe(2'b11, 24'h000100, 24'hFFFF00);
    wait_issue("t2a", 60, at);
    chk("t2_first_cyc", at, FIRST_ISSUE);
    chk("t2_first_ch", eng_ch, 0);
    chk("t2_first_data", eng_data, 24'h000100);
    wait_issue("t2b", 60, at2);
    chk("t2_spacing", at2 - at, SLOT);
    chk("t2_second_ch", eng_ch, 1);
    chk("t2_second_data", eng_data, 24'hFFFF00);

    // 3: double strobe on ch1 -> single issue of newest value
    do_reset();
    strobe(2'b10, 24'h0, 24'h000011);
    strobe(2'b10, 24'h0, 24'h000022);
    wait_issue("t3", 60, at);
    chk("t3_ch", eng_ch, 1);
    chk("t3_data", eng_data, 24'h000022);
`ifdef CIC_SCHED_OVERRUN_EN
    ov_exp = 2'b10;
`else
    ov_exp = 2'b00;
`endif
    chk("t3_overrun", overrun, ov_exp);
    nis = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (eng_strobe) nis++;
    end
    chk("t3_no_reissue", nis, 0);

    // 4: output tagging; engine output during holdoff is discarded
    do_reset();
    tick();
    eng_out_strobe = 1'b1;
    eng_out_data = 24'h777777;
    tick();
    eng_out_strobe = 1'b0;
    chk("t4_holdoff_drop", out_strobe, 0);
    chk("t4_holdoff_data", out_data, 0);
    strobe(2'b10, 24'h0, 24'h000005);
    wait_issue("t4", 60, at);
    chk("t4_issue_ch", eng_ch, 1);
    for (int i = 0; i < 5; i++) tick();
    eng_out_strobe = 1'b1;
    eng_out_data = 24'h123456;
    tick();
    eng_out_strobe = 1'b0;
    chk("t4_out_strobe", out_strobe, 1);
    chk("t4_out_ch", out_ch, 1);
    chk("t4_out_data", out_data, 24'h123456);
    tick();
    chk("t4_out_pulse", out_strobe, 0);

    // 5: both channels strobed every 10 clocks -> strict alternation
    do_reset();
    order.delete();
    for (int k = 0; k < 200; k++) begin
      in_strobe = (k % 10 == 0) ? 2'b11 : 2'b00;
      in_data = {24'h0B0000 + 24'(k), 24'h0A0000 + 24'(k)};
      tick();
      if (eng_strobe) order.push_back(eng_ch);
    end
    in_strobe = '0;
    chk("t5_count", order.size(), 6);
    foreach (order[i]) chk($sformatf("t5_order%0d", i), order[i], i % 2);

    // 6: async reset mid-slot clears outputs at once; full holdoff repeats
    do_reset();
    strobe(2'b10, 24'h0, 24'h0000CC);
    wait_issue("t6a", 60, at);
    for (int i = 0; i < 3; i++) tick();
    eng_out_strobe = 1'b1;
    eng_out_data = 24'h0ABCDE;
    tick();
    eng_out_strobe = 1'b0;
    chk("t6_pre_out", out_data, 24'h0ABCDE);
    #1;
    reset = 1'b1;
    #1;
    chk("t6_rst_eng_ch", eng_ch, 0);
    chk("t6_rst_eng_data", eng_data, 0);
    chk("t6_rst_out_data", out_data, 0);
    chk("t6_rst_out_ch", out_ch, 0);
    do_reset();
    strobe(2'b01, 24'h000033, 24'h0);
    wait_issue("t6b", 60, at);
    chk("t6_holdoff_again", at, FIRST_ISSUE);
    chk("t6_ch", eng_ch, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
